// File: rtl/rotate_pkg.sv
// Shared op codes, FSM state encoding and op classification for the rotate/shift unit.
package rotate_pkg;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ROL  = 3'b001;
    localparam logic [2:0] OP_ROR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_SHR  = 3'b100;
    localparam logic [2:0] OP_SAR  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // True for ops that actually move bits; LOAD and the reserved codes do not.
    function automatic logic op_moves(input logic [2:0] op);
        return (op == OP_ROL) || (op == OP_ROR) || (op == OP_SHL) ||
               (op == OP_SHR) || (op == OP_SAR);
    endfunction

endpackage

// File: rtl/rotate_step.sv
// Combinational single-bit rotate/shift step; LOAD and reserved codes pass the value through.
module rotate_step
    import rotate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_in,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] q_out,
    output logic             carry_out
);

    always_comb begin
        q_out     = q_in;
        carry_out = 1'b0;
        case (op)
            OP_ROL: begin
                q_out     = {q_in[WIDTH-2:0], q_in[WIDTH-1]};
                carry_out = q_in[WIDTH-1];
            end
            OP_ROR: begin
                q_out     = {q_in[0], q_in[WIDTH-1:1]};
                carry_out = q_in[0];
            end
            OP_SHL: begin
                q_out     = {q_in[WIDTH-2:0], 1'b0};
                carry_out = q_in[WIDTH-1];
            end
            OP_SHR: begin
                q_out     = {1'b0, q_in[WIDTH-1:1]};
                carry_out = q_in[0];
            end
            OP_SAR: begin
                q_out     = {q_in[WIDTH-1], q_in[WIDTH-1:1]};
                carry_out = q_in[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rotate_shift_unit.sv
// Load/rotate/shift engine with start/busy/done handshake, one bit per clock.
// Define ROTATE_SHIFT_BARREL_EN to compute the whole result at the accepting edge instead.
module rotate_shift_unit
    import rotate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             carry_q, carry_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;

    logic [WIDTH-1:0] step_q;
    logic             step_carry;

    rotate_step #(.WIDTH(WIDTH)) u_step (
        .q_in      (q_q),
        .op        (op_q),
        .q_out     (step_q),
        .carry_out (step_carry)
    );

`ifdef ROTATE_SHIFT_BARREL_EN
    // Stage k holds the operand after k steps; amt selects the final stage.
    logic [WIDTH-1:0] stage_val   [WIDTH];
    logic             stage_carry [WIDTH];
    logic [WIDTH-1:0] barrel_q;
    logic             barrel_carry;

    assign stage_val[0]   = data;
    assign stage_carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_barrel
            rotate_step #(.WIDTH(WIDTH)) u_stage (
                .q_in      (stage_val[gi]),
                .op        (op),
                .q_out     (stage_val[gi+1]),
                .carry_out (stage_carry[gi+1])
            );
        end
    endgenerate

    always_comb begin
        barrel_q     = data;
        barrel_carry = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (amt == AMT_W'(i)) begin
                barrel_q     = stage_val[i];
                barrel_carry = stage_carry[i];
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = amt;
`ifdef ROTATE_SHIFT_BARREL_EN
                    q_d     = barrel_q;
                    carry_d = barrel_carry;
                    state_d = S_DONE;
`else
                    q_d     = data;
                    carry_d = 1'b0;
                    state_d = (op_moves(op) && (amt != '0)) ? S_RUN : S_DONE;
`endif
                end
            end
            S_RUN: begin
                q_d     = step_q;
                carry_d = step_carry;
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            op_q    <= OP_LOAD;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign q     = q_q;
    assign carry = carry_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);

endmodule

// File: doc/rotate_shift_unit.md
Name: rotate_shift_unit

Overview:
- Parametrised successor to the fixed-width load/rotate register.
- Loads an operand and then rotates or shifts it left or right by a run-time amount.
- Supports logical and arithmetic right shift, and reports the last bit shifted out (carry).
- Iterative datapath: one bit per clock, with start/busy/done handshake. Used as the shift/rotate engine in the datapath labs.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- AMT_W, $clog2(WIDTH), width of the amount input.

Ports:
- clk    input   1        system clock; all state changes on posedge clk.
- rst    input   1        reset, synchronous, active-low.
- start  input   1        request; sampled only when busy=0.
- op     input   3        operation code, latched with start.
- data   input   WIDTH    operand, latched with start.
- amt    input   AMT_W    step count, latched with start.
- q      output  WIDTH    result register.
- carry  output  1        last bit shifted or rotated out.
- busy   output  1        high while an operation is in progress (RUN or DONE).
- done   output  1        one-cycle pulse when q/carry are final.

Behaviour:
- Reset (rst=0 at a clk edge): q=0, carry=0, busy=0, done=0, state=IDLE, internal counter=0. Reset overrides everything.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- Op codes:
  - 000 LOAD
  - 001 ROL
  - 010 ROR
  - 011 SHL (zero fill)
  - 100 SHR (zero fill)
  - 101 SAR (MSB replicated)
  - 110/111 reserved; behave as LOAD.
- State machine IDLE / RUN / DONE:
  - IDLE:
    - start=1 at an edge: q<=data, carry<=0, cnt<=amt, op latched.
    - Next state is DONE if op is LOAD/reserved or amt==0; otherwise RUN.
    - start=0: q and carry hold.
  - RUN: each edge applies one step to q, carry<=bit leaving q, cnt<=cnt-1. When cnt==1 at that edge, next state is DONE.
  - DONE: done=1 for exactly this cycle; next edge returns to IDLE.
  - busy=1 in RUN and DONE.
- One step:
  - ROL: q<={q[W-2:0],q[W-1]}, carry<=q[W-1].
  - ROR: q<={q[0],q[W-1:1]}, carry<=q[0].
  - SHL: q<={q[W-2:0],0}, carry<=q[W-1].
  - SHR: q<={0,q[W-1:1]}, carry<=q[0].
  - SAR: q<={q[W-1],q[W-1:1]}, carry<=q[0].
- Latency: start at edge 0 → done high in the cycle after edge amt. That is amt+1 cycles from start, or 1 cycle for amt=0 or LOAD.
- start while busy=1 is ignored; no queuing.
- Inputs data/op/amt are don't-care except at the accepting edge.
- q and carry remain stable from DONE until the next accepted start.
- Rotations by amt produce the same result as amt mod WIDTH, but still take amt steps. The maximum amt is WIDTH-1 for all ops.

Optional Feature:
- Macro ROTATE_SHIFT_BARREL_EN.
- Defined: the full result and carry are computed combinationally from data/op/amt and registered at the accepting edge. State goes straight to DONE, so latency is 1 cycle for every amt; the RUN state is unused. Final q and carry are bit-identical to the iterative mode.
- Undefined: iterative one-bit-per-cycle operation as above.

Decomposition:
- Package rotate_pkg holds:
  - op code localparams (OP_LOAD, OP_ROL, OP_ROR, OP_SHL, OP_SHR, OP_SAR)
  - state encoding (S_IDLE, S_RUN, S_DONE)
- Sub-module rotate_step: purely combinational single-bit step taking q_in and op, producing q_out and carry_out.
  - Instanced once in iterative mode.
  - Chained or looped to form the barrel when ROTATE_SHIFT_BARREL_EN is defined.

Test Plan (WIDTH=8):
- rst=0 for 2 cycles during a RUN of ROL amt=5 → q=0x00, carry=0, busy=0, no done pulse. After rst=1, IDLE accepts a new start.
- ROL data=8'b1000_0001 amt=1 → q=8'b0000_0011, carry=1, done 2 cycles after start (barrel: 1 cycle).
- ROR data=0xA5 amt=3 → q=0xB4, carry=1, done 4 cycles after start. SAR data=0x90 amt=2 → q=0xE4, carry=0.
- SHL data=0xFF amt=7 → q=0x80, carry=1, busy high 8 cycles. start pulsed with data=0x11 mid-run is ignored; result unchanged.
- ROL data=0x3C amt=0, and LOAD data=0x5A amt=6 → q=0x3C and q=0x5A respectively, carry=0, done 1 cycle after start.
- Back-to-back: start asserted in the cycle after done → accepted. q/carry held constant across the idle gap while start=0.
